// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-CPU control unit: opcodes, ALU selects, states, IR layout.
// SEQ_MULDIV_EN adds the MUL/DIV opcodes and the extra T6 state.
package cpu_pkg;

    localparam int OPC_ADD  = 5'b00011;
    localparam int OPC_SUB  = 5'b00100;
    localparam int OPC_AND  = 5'b01001;
    localparam int OPC_OR   = 5'b01010;
    localparam int OPC_HALT = 5'b11011;
    localparam int OPC_MUL  = 5'b01111;
    localparam int OPC_DIV  = 5'b10000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;
    localparam logic [3:0] ALU_DIV = 4'd5;

    // Register fields sit directly below the opcode; gaps count bits down from the opcode LSB.
    localparam int REG_IDX_W = 4;
    localparam int RA_GAP    = 0;
    localparam int RB_GAP    = 4;
    localparam int RC_GAP    = 8;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
`ifdef SEQ_MULDIV_EN
        ST_T6     = 4'd7,
`endif
        ST_HALTED = 4'd8
    } state_t;

    function automatic logic opc_legal(input int opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_HALT: return 1'b1;
`ifdef SEQ_MULDIV_EN
            OPC_MUL, OPC_DIV: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input int opc);
        case (opc)
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_OR:  return ALU_OR;
            OPC_MUL: return ALU_MUL;
            OPC_DIV: return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

`ifdef SEQ_MULDIV_EN
    function automatic logic opc_is_muldiv(input int opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction
`endif

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot select; o_oor flags an index beyond NUM_REGS regardless of enable.
module reg_sel_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot,
    output logic                o_oor
);

    assign o_oor = (int'(i_idx) >= NUM_REGS);

    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_onehot[k] = i_en && (int'(i_idx) == k);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Hard-wired T-state control unit driving the bus CPU datapath strobes (Moore outputs).
// Optional macro SEQ_MULDIV_EN enables MUL/DIV with a T6 state writing HI/LO.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic                Mem_ready,
    input  logic [DATA_W-1:0]   IR_q,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic                Hiin,
    output logic                Loin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [3:0]          Alu_op,
    output logic                Busy,
    output logic                Done,
    output logic                Halted,
    output logic                Illegal
);

    localparam int OPC_LSB = DATA_W - OPC_W;
    localparam int RA_MSB  = OPC_LSB - 1 - RA_GAP;
    localparam int RB_MSB  = OPC_LSB - 1 - RB_GAP;
    localparam int RC_MSB  = OPC_LSB - 1 - RC_GAP;
    localparam int RC_LSB  = RC_MSB - REG_IDX_W + 1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_illegal;

    logic [OPC_W-1:0]     w_opc;
    int                   w_opc_i;
    logic [REG_IDX_W-1:0] w_ra;
    logic [REG_IDX_W-1:0] w_rb;
    logic [REG_IDX_W-1:0] w_rc;
    logic [REG_IDX_W-1:0] w_rout_idx;
    logic                 w_ra_oor;
    logic                 w_rc_oor;
    logic                 w_rout_oor;
    logic                 w_is_halt;
    logic                 w_bad;
    logic                 w_rin_en;
    logic                 w_rout_en;
    logic                 w_unused_ir;

    assign w_opc       = IR_q[DATA_W-1 -: OPC_W];
    assign w_opc_i     = int'(w_opc);
    assign w_ra        = IR_q[RA_MSB -: REG_IDX_W];
    assign w_rb        = IR_q[RB_MSB -: REG_IDX_W];
    assign w_rc        = IR_q[RC_MSB -: REG_IDX_W];
    assign w_unused_ir = ^IR_q[RC_LSB-1:0];

    // Rout drives Rb in T3 and Rc in T4; during T3 its range flag therefore checks Rb.
    assign w_rout_idx = (r_state == ST_T4) ? w_rc : w_rb;
    assign w_rc_oor   = (int'(w_rc) >= NUM_REGS);
    assign w_is_halt  = (w_opc_i == OPC_HALT);
    assign w_bad      = !opc_legal(w_opc_i) || w_ra_oor || w_rout_oor || w_rc_oor;

    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .i_idx    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin),
        .o_oor    (w_ra_oor)
    );

    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout),
        .o_oor    (w_rout_oor)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= ST_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_T3 && !w_is_halt && w_bad) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign Illegal = r_illegal;

    always_comb begin
        w_state_nxt = r_state;
        PCout       = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        MDRout      = 1'b0;
        MARin       = 1'b0;
        Zin         = 1'b0;
        PCin        = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        Hiin        = 1'b0;
        Loin        = 1'b0;
        Alu_op      = 4'd0;
        Done        = 1'b0;
        w_rin_en    = 1'b0;
        w_rout_en   = 1'b0;
        Busy        = (r_state != ST_IDLE) && (r_state != ST_HALTED);
        Halted      = (r_state == ST_HALTED);

        case (r_state)
            ST_IDLE: begin
                if (Run) w_state_nxt = ST_T0;
            end
            ST_T0: begin
                PCout       = 1'b1;
                MARin       = 1'b1;
                IncPC       = 1'b1;
                Zin         = 1'b1;
                w_state_nxt = ST_T1;
            end
            // Holding PCin while waiting just reloads the same Z value each cycle.
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (Mem_ready) w_state_nxt = ST_T2;
            end
            ST_T2: begin
                MDRout      = 1'b1;
                IRin        = 1'b1;
                w_state_nxt = ST_T3;
            end
            ST_T3: begin
                if (w_is_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_bad) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rout_en   = 1'b1;
                    Yin         = 1'b1;
                    w_state_nxt = ST_T4;
                end
            end
            ST_T4: begin
                w_rout_en   = 1'b1;
                Zin         = 1'b1;
                Alu_op      = alu_of(w_opc_i);
                w_state_nxt = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (opc_is_muldiv(w_opc_i)) begin
                    Loin        = 1'b1;
                    w_state_nxt = ST_T6;
                end else
`endif
                begin
                    w_rin_en    = 1'b1;
                    Done        = 1'b1;
                    w_state_nxt = Run ? ST_T0 : ST_IDLE;
                end
            end
`ifdef SEQ_MULDIV_EN
            ST_T6: begin
                Zhighout    = 1'b1;
                Hiin        = 1'b1;
                Done        = 1'b1;
                w_state_nxt = Run ? ST_T0 : ST_IDLE;
            end
`endif
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Hard-wired control unit for the bus-based CPU datapath.
- Fetches an instruction, decodes its three-register format and executes it in T-states by driving the datapath strobes: PCout, MARin, Zin, Yin, Rin/Rout and related signals.
- Generalises the fixed AND-only sequence to parametrised width and register count, several ALU operations, a memory-ready handshake, and HALT/illegal handling.
- Sits beside the datapath; its outputs connect directly to the datapath's control inputs.

Parameters:
- DATA_W, 32: bus and IR width.
- NUM_REGS, 16: number of general registers; width of the Rin/Rout vectors, at most 16.
- OPC_W, 5: opcode field width, IR[DATA_W-1 -: OPC_W].

Ports:
- Clock  in  1  system clock; rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  level; start or continue executing instructions.
- Mem_ready  in  1  memory read data is valid on Mdatain this cycle.
- IR_q  in  DATA_W  datapath IR register output.
- PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Hiin, Loin  out  1 each  datapath strobes.
- Rin  out  NUM_REGS  one-hot register load enable.
- Rout  out  NUM_REGS  one-hot register bus drive.
- Alu_op  out  4  ALU operation select.
- Busy  out  1  high in every state except IDLE and HALTED.
- Done  out  1  one-cycle pulse at instruction completion (T5).
- Halted  out  1  high in the HALTED state.
- Illegal  out  1  sticky flag for an illegal instruction.

Behaviour:
- Instruction fields: opcode = IR[31:27]; Ra = IR[26:23] (destination); Rb = IR[22:19]; Rc = IR[18:15].
- Example: 0x4A920000 decodes to "and R5,R2,R4".
- Opcodes:
  - ADD 00011
  - SUB 00100
  - AND 01001
  - OR 01010
  - HALT 11011
  - any other value is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALTED.
- The state is a register. Outputs are decoded from the state and IR_q only (Moore-style); no other output registers.
- Reset: asynchronous entry to IDLE. Every output is 0 and Illegal is cleared, immediately and including mid-instruction.
- IDLE: all outputs 0. Moves to T0 when Run=1 is sampled.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while Mem_ready=0; all four signals remain high. Re-loading PC from the unchanged Z is idempotent.
  - Moves to T2 on the edge where Mem_ready=1.
- T2: MDRout, IRin. IR_q is valid from T3 onward.
- T3:
  - HALT goes to HALTED with no register strobes.
  - Illegal opcode, or Ra/Rb/Rc >= NUM_REGS: set Illegal and go to IDLE.
  - Otherwise assert Rout[Rb] and Yin.
- T4: Rout[Rc], Zin, Alu_op per opcode.
- T5: Zlowout, Rin[Ra], Done. Then go to T0 if Run=1, else IDLE.
- Alu_op is 0 outside T4.
- Rin and Rout are each exactly one-hot or all zero. R0 is an ordinary register.
- HALTED: exits only on reset; Run is ignored.
- Illegal clears only on reset; a later Run still starts a new fetch.
- Run falling mid-instruction has no effect; the current instruction completes.
- Latency with Mem_ready=1: 6 cycles per instruction, back-to-back with Run held high.

Optional Feature:
- Macro: SEQ_MULDIV_EN.
- Defined:
  - Opcodes MUL 01111 and DIV 10000 become legal.
  - T4 asserts Rout[Rc], Zin and Alu_op MUL/DIV (Ra unused).
  - T5 asserts Zlowout and Loin.
  - An added state T6 asserts Zhighout and Hiin, then follows the T5 exit rule.
  - Done pulses in T6 instead of T5.
- Undefined: both opcodes are illegal; Zhighout, Hiin and Loin are tied to 0; T6 does not exist.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants
  - Alu_op encodings: ADD=0, SUB=1, AND=2, OR=3, MUL=4, DIV=5
  - state encoding
  - IR field bit positions
- One sub-module, reg_sel_decoder: turns a 4-bit register index plus an enable into a NUM_REGS-wide one-hot vector, with an out-of-range flag. It is instantiated for Rin and Rout.

Test Plan:
- Directed AND: IR_q=0x4A920000, Mem_ready=1, Run pulsed.
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0010, Alu_op=2, Zin=1.
  - T5: Rin=0x0020, Done=1.
  - Back in IDLE 6 cycles after T0.
- Memory wait: Mem_ready held low for 3 cycles in T1 -> T1 lasts 4 cycles, with Read, MDRin and PCin high for all 4; T2 follows on the next edge.
- Illegal opcode: IR_q=0xF8000000 -> Illegal=1 after T3, no Rin/Rout/Yin asserted, state returns to IDLE; Illegal persists until Resetn is asserted.
- Halt: IR_q=0xD8000000 -> Halted=1 and Busy=0 from the cycle after T3; Run=1 for 10 cycles produces no change.
- Reset mid-op: Resetn driven low during T4 (between edges) -> Rout, Zin and Alu_op go to 0 immediately; after release the block is in IDLE.
- With SEQ_MULDIV_EN: IR_q=0x78110000 (MUL, Rb=R2, Rc=R2).
  - T4: Alu_op=4.
  - T5: Loin=1.
  - T6: Hiin=1, Zhighout=1, Done=1.
